// File: rtl/sva_verdict_monitor.sv
// Verdict monitor for SVA checker results: arms on command, counts verdicts with
// saturation, timestamps the first failure and logs every failure timestamp into a FIFO.
module sva_verdict_monitor #(
  parameter int CNT_WIDTH  = 16,
  parameter int TS_WIDTH   = 16,
  parameter int LOG_DEPTH  = 4,
  parameter int FAIL_LIMIT = 1
) (
  input  logic                 gclk,
  input  logic                 grst,
  input  logic                 i_arm,
  input  logic                 i_clr,
  input  logic                 i_res_vld,
  input  logic                 i_res_succ,
  input  logic                 i_res_fail,
  input  logic                 i_res_lazy,
  output logic [1:0]           o_state,
  output logic [CNT_WIDTH-1:0] o_succ_cnt,
  output logic [CNT_WIDTH-1:0] o_fail_cnt,
  output logic [CNT_WIDTH-1:0] o_lazy_cnt,
  output logic                 o_first_fail_vld,
  output logic [TS_WIDTH-1:0]  o_first_fail_ts,
  output logic                 o_log_rd_vld,
  input  logic                 i_log_rd_rdy,
  output logic [TS_WIDTH-1:0]  o_log_rd_ts,
  output logic                 o_log_overflow
);

  localparam int AW = $clog2(LOG_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(FAIL_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_FAILED = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [TS_WIDTH-1:0]    r_ts;
  logic [CNT_WIDTH-1:0]   r_succ_cnt;
  logic [CNT_WIDTH-1:0]   r_fail_cnt;
  logic [CNT_WIDTH-1:0]   r_lazy_cnt;
  logic [CNT_WIDTH-1:0]   w_fail_nxt;
  logic                   r_first_fail_vld;
  logic [TS_WIDTH-1:0]    r_first_fail_ts;
  logic [TS_WIDTH-1:0]    r_mem [LOG_DEPTH];
  logic [AW:0]            r_wr_ptr;
  logic [AW:0]            r_rd_ptr;
  logic                   r_overflow;
  logic                   w_count;
  logic                   w_succ_inc;
  logic                   w_fail_inc;
  logic                   w_lazy_inc;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;

  // A clr cycle suppresses counting; an arm cycle only matters in IDLE, where nothing counts.
  assign w_count    = (r_state != ST_IDLE) && i_res_vld && !i_clr;
  assign w_succ_inc = w_count && i_res_succ;
  assign w_fail_inc = w_count && i_res_fail;
  assign w_lazy_inc = w_count && i_res_lazy;
  assign w_fail_nxt = (w_fail_inc && r_fail_cnt != CNT_MAX) ? r_fail_cnt + 1'b1 : r_fail_cnt;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && i_log_rd_rdy;
  assign w_push  = w_fail_inc && (!w_full || w_pop);
  assign w_drop  = w_fail_inc && w_full && !w_pop;

  always_comb begin
    w_state_nxt = r_state;
    if (i_clr) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (i_arm) w_state_nxt = ST_ARMED;
        ST_ARMED:  if (w_fail_inc && w_fail_nxt >= CNT_LIMIT) w_state_nxt = ST_FAILED;
        ST_FAILED: w_state_nxt = ST_FAILED;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      r_state <= ST_IDLE;
      r_ts    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ts    <= r_ts + 1'b1;
    end
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      r_succ_cnt       <= '0;
      r_fail_cnt       <= '0;
      r_lazy_cnt       <= '0;
      r_first_fail_vld <= 1'b0;
      r_first_fail_ts  <= '0;
    end else if (i_clr) begin
      r_succ_cnt       <= '0;
      r_fail_cnt       <= '0;
      r_lazy_cnt       <= '0;
      r_first_fail_vld <= 1'b0;
      r_first_fail_ts  <= '0;
    end else begin
      if (w_succ_inc && r_succ_cnt != CNT_MAX) r_succ_cnt <= r_succ_cnt + 1'b1;
      if (w_lazy_inc && r_lazy_cnt != CNT_MAX) r_lazy_cnt <= r_lazy_cnt + 1'b1;
      r_fail_cnt <= w_fail_nxt;
      if (w_fail_inc && !r_first_fail_vld) begin
        r_first_fail_vld <= 1'b1;
        r_first_fail_ts  <= r_ts;
      end
    end
  end

  // Storage is cleared only by grst; clr just empties the log via the pointers.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      for (int i = 0; i < LOG_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_ts;
    end
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign o_state          = r_state;
  assign o_succ_cnt       = r_succ_cnt;
  assign o_fail_cnt       = r_fail_cnt;
  assign o_lazy_cnt       = r_lazy_cnt;
  assign o_first_fail_vld = r_first_fail_vld;
  assign o_first_fail_ts  = r_first_fail_ts;
  assign o_log_rd_vld     = !w_empty;
  assign o_log_rd_ts      = r_mem[r_rd_ptr[AW-1:0]];
  assign o_log_overflow   = r_overflow;

endmodule

// File: tb/tb_sva_verdict_monitor.sv
// Randomized and directed bench for sva_verdict_monitor against a queue-based
// reference model of the verdict/log behaviour.
module tb_sva_verdict_monitor;

  localparam int CW    = 3;
  localparam int TW    = 8;
  localparam int DEPTH = 4;
  localparam int LIMIT = 1;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int TMOD  = 1 << TW;

  logic          gclk = 1'b0;
  logic          grst;
  logic          arm, clr, resVld, resSucc, resFail, resLazy, logRdRdy;
  logic [1:0]    state;
  logic [CW-1:0] succCnt, failCnt, lazyCnt;
  logic          firstFailVld;
  logic [TW-1:0] firstFailTs;
  logic          logRdVld;
  logic [TW-1:0] logRdTs;
  logic          logOverflow;

  int nCompared   = 0;
  int nMismatched = 0;

  int mState, mSucc, mFail, mLazy, mFfv, mFfts, mOvf, mTs;
  int mLog[$];

  sva_verdict_monitor #(
    .CNT_WIDTH(CW), .TS_WIDTH(TW), .LOG_DEPTH(DEPTH), .FAIL_LIMIT(LIMIT)
  ) dut (
    .gclk(gclk), .grst(grst),
    .i_arm(arm), .i_clr(clr),
    .i_res_vld(resVld), .i_res_succ(resSucc), .i_res_fail(resFail), .i_res_lazy(resLazy),
    .o_state(state), .o_succ_cnt(succCnt), .o_fail_cnt(failCnt), .o_lazy_cnt(lazyCnt),
    .o_first_fail_vld(firstFailVld), .o_first_fail_ts(firstFailTs),
    .o_log_rd_vld(logRdVld), .i_log_rd_rdy(logRdRdy), .o_log_rd_ts(logRdTs),
    .o_log_overflow(logOverflow)
  );

  always #5 gclk = ~gclk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nCompared++;
    if (observed != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  task automatic modelReset();
    mState = 0; mSucc = 0; mFail = 0; mLazy = 0;
    mFfv = 0; mFfts = 0; mOvf = 0; mTs = 0;
    mLog.delete();
  endtask

  // One clock edge of the reference behaviour, using the inputs sampled at that edge.
  task automatic modelStep();
    bit pop, push;
    pop  = (mLog.size() > 0) && logRdRdy;
    push = 0;
    if (clr) begin
      mState = 0; mSucc = 0; mFail = 0; mLazy = 0;
      mFfv = 0; mFfts = 0; mOvf = 0;
      mLog.delete();
    end else begin
      if (mState == 0) begin
        if (arm) mState = 1;
      end else if (resVld) begin
        if (resSucc) mSucc = (mSucc < CMAX) ? mSucc + 1 : CMAX;
        if (resLazy) mLazy = (mLazy < CMAX) ? mLazy + 1 : CMAX;
        if (resFail) begin
          mFail = (mFail < CMAX) ? mFail + 1 : CMAX;
          push = 1;
          if (!mFfv) begin mFfv = 1; mFfts = mTs; end
          if (mState == 1 && mFail >= LIMIT) mState = 2;
        end
      end
      if (pop) void'(mLog.pop_front());
      if (push) begin
        if (mLog.size() < DEPTH) mLog.push_back(mTs);
        else mOvf = 1;
      end
    end
    mTs = (mTs + 1) % TMOD;
  endtask

  task automatic compareModel();
    checkOutput("state", int'(state), mState);
    checkOutput("succ_cnt", int'(succCnt), mSucc);
    checkOutput("fail_cnt", int'(failCnt), mFail);
    checkOutput("lazy_cnt", int'(lazyCnt), mLazy);
    checkOutput("first_fail_vld", int'(firstFailVld), mFfv);
    checkOutput("first_fail_ts", int'(firstFailTs), mFfts);
    checkOutput("log_rd_vld", int'(logRdVld), (mLog.size() > 0) ? 1 : 0);
    if (mLog.size() > 0) checkOutput("log_rd_ts", int'(logRdTs), mLog[0]);
    checkOutput("log_overflow", int'(logOverflow), mOvf);
  endtask

  task automatic applyStimulus(input bit a, input bit c, input bit v, input bit s,
                               input bit f, input bit l, input bit r);
    arm = a; clr = c; resVld = v; resSucc = s; resFail = f; resLazy = l; logRdRdy = r;
    @(posedge gclk);
    modelStep();
    #1;
    compareModel();
  endtask

  task automatic idleInputs();
    arm = 0; clr = 0; resVld = 0; resSucc = 0; resFail = 0; resLazy = 0; logRdRdy = 0;
  endtask

  // Asserts grst between edges, checks the asynchronous reset values, releases before the next edge.
  task automatic doReset();
    idleInputs();
    grst = 1'b1;
    #1;
    modelReset();
    compareModel();
    @(negedge gclk);
    grst = 1'b0;
  endtask

  initial begin
    int pops;
    grst = 1'b1;
    idleInputs();
    modelReset();
    #12;
    doReset();

    // Plain successes after arm.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 1, 1, 0, 0, 0);
    checkOutput("succ_after_3", int'(succCnt), 3);
    checkOutput("fail_after_3", int'(failCnt), 0);
    checkOutput("state_armed", int'(state), 1);
    checkOutput("log_empty", int'(logRdVld), 0);

    // Verdicts before arm and in the arm cycle are ignored.
    doReset();
    repeat (3) applyStimulus(0, 0, 1, 1, 1, 1, 0);
    applyStimulus(1, 0, 1, 1, 1, 1, 0);
    checkOutput("pre_arm_fail_cnt", int'(failCnt), 0);
    checkOutput("pre_arm_succ_cnt", int'(succCnt), 0);
    checkOutput("pre_arm_ffv", int'(firstFailVld), 0);

    // Fails at ts=10 and ts=14, then drain the log.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    while (mTs != 10) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 0, 0);
    checkOutput("failed_from_ts11", int'(state), 2);
    while (mTs != 14) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 0, 0);
    checkOutput("first_fail_ts10", int'(firstFailTs), 10);
    checkOutput("log_head_10", int'(logRdTs), 10);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("log_head_14", int'(logRdTs), 14);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("log_drained", int'(logRdVld), 0);

    // Overflow: five fails into a four-deep log with no reader.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    repeat (5) applyStimulus(0, 0, 1, 0, 1, 0, 0);
    checkOutput("ovf_fail_cnt", int'(failCnt), 5);
    checkOutput("ovf_sticky", int'(logOverflow), 1);
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Full log with simultaneous push and pop.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 1, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 0, 1);
    checkOutput("push_pop_no_ovf", int'(logOverflow), 0);
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      if (logRdVld) pops++;
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
    end
    checkOutput("occupancy_4", pops, 4);

    // Saturation, then clr alongside a fail.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    repeat (CMAX + 2) applyStimulus(0, 0, 1, 1, 0, 1, 0);
    checkOutput("succ_saturated", int'(succCnt), CMAX);
    applyStimulus(0, 1, 1, 1, 1, 1, 0);
    checkOutput("clr_state_idle", int'(state), 0);
    checkOutput("clr_fail_cnt", int'(failCnt), 0);
    checkOutput("clr_succ_cnt", int'(succCnt), 0);

    // Randomized traffic, including ts wraparound and a mid-run reset.
    doReset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit a, c;
      a = (mState == 0) && ($urandom_range(3) == 0);
      c = ($urandom_range(59) == 0);
      applyStimulus(a, c, $urandom_range(9) < 7, 1'($urandom), $urandom_range(3) == 0,
                    1'($urandom), $urandom_range(2) == 0);
      if (cyc == 700) begin
        @(posedge gclk);
        #3;
        modelStep();
        doReset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
